// File: rtl/eqt_pkg.sv
// Shared types and default widths for the equivalent-time sampler.
package eqt_pkg;

   localparam int EQT_T_CNT_W = 32;
   localparam int EQT_AVG_W   = 16;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ARM      = 3'd1,
      ST_WAIT_DLY = 3'd2,
      ST_SAMPLE   = 3'd3,
      ST_EMIT     = 3'd4,
      ST_DONE     = 3'd5
   } eqt_state_e;

endpackage

// File: rtl/eqt_dly_cnt.sv
// Strobe-referenced counter: load a start value, count up, flag equality
// with a compare value. Used for the sample delay and for the watchdog.
module eqt_dly_cnt #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         arst_ni,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         inc_i,
   input  logic [W-1:0] cmp_i,
   output logic         eq_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (inc_i) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign eq_o = (cnt_q == cmp_i);

endmodule

// File: rtl/eqt_sampler.sv
// Equivalent-time sampler: sweeps a sample delay across the strobe period and
// streams one hit count per delay point. Optional watchdog: EQT_TIMEOUT_EN.
module eqt_sampler
   import eqt_pkg::*;
#(
   parameter int T_CNT_WIDTH = EQT_T_CNT_W,
   parameter int AVG_WIDTH   = EQT_AVG_W
) (
   input  logic                   clk_i,
   input  logic                   arst_ni,
   input  logic                   start_i,
   input  logic                   abort_i,
   input  logic                   stb_i,
   input  logic                   period_vld_i,
   input  logic [T_CNT_WIDTH-1:0] stb_period_i,
   input  logic                   sig_i,
   input  logic [T_CNT_WIDTH-1:0] step_i,
   input  logic [AVG_WIDTH-1:0]   n_avg_i,
   output logic                   pt_vld_o,
   input  logic                   pt_rdy_i,
   output logic [T_CNT_WIDTH-1:0] pt_delay_o,
   output logic [AVG_WIDTH-1:0]   pt_hits_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   err_o,
   output eqt_state_e             dbg_state_o
);

   // Point handshake: a point transfers on a cycle where pt_vld_o and
   // pt_rdy_i are both high; pt_vld_o, pt_delay_o and pt_hits_o hold until then.

   eqt_state_e             state_q, state_d;
   logic [T_CNT_WIDTH-1:0] period_q, period_d;
   logic [T_CNT_WIDTH-1:0] step_q, step_d;
   logic [T_CNT_WIDTH-1:0] delay_q, delay_d;
   logic [AVG_WIDTH-1:0]   navg_q, navg_d;
   logic [AVG_WIDTH-1:0]   hits_q, hits_d;
   logic [AVG_WIDTH-1:0]   nsamp_q, nsamp_d;
   logic                   err_q, err_d;
   logic                   pt_vld_q, busy_q, done_q;

   logic [T_CNT_WIDTH:0]   delay_sum;
   logic [AVG_WIDTH-1:0]   hits_inc;
   logic                   dly_eq;
   logic                   take_sample;
   logic                   wd_to;

   eqt_dly_cnt #(.W(T_CNT_WIDTH)) u_dly_cnt (
      .clk_i      (clk_i),
      .arst_ni    (arst_ni),
      .load_i     (stb_i && (state_q == ST_ARM || state_q == ST_WAIT_DLY)),
      .load_val_i (T_CNT_WIDTH'(1)),
      .inc_i      (state_q == ST_WAIT_DLY),
      .cmp_i      (delay_q),
      .eq_o       (dly_eq)
   );

`ifdef EQT_TIMEOUT_EN
   logic wd_run, wd_eq;
   assign wd_run = (state_q == ST_ARM) || (state_q == ST_WAIT_DLY);

   // Held at zero outside ARM/WAIT_DLY and on every strobe.
   eqt_dly_cnt #(.W(T_CNT_WIDTH+1)) u_wd_cnt (
      .clk_i      (clk_i),
      .arst_ni    (arst_ni),
      .load_i     (stb_i || !wd_run),
      .load_val_i ('0),
      .inc_i      (wd_run),
      .cmp_i      ({period_q, 1'b0}),
      .eq_o       (wd_eq)
   );
   assign wd_to = wd_run && wd_eq && !stb_i;
`else
   assign wd_to = 1'b0;
`endif

   // Delay 0 samples on the strobe cycle; an early strobe in WAIT_DLY wins
   // over a coincident compare and restarts the count.
   assign take_sample = (state_q == ST_ARM && stb_i && delay_q == '0) ||
                        (state_q == ST_WAIT_DLY && !stb_i && dly_eq);

   assign delay_sum = {1'b0, delay_q} + {1'b0, step_q};
   assign hits_inc  = (&hits_q) ? hits_q : hits_q + {{(AVG_WIDTH-1){1'b0}}, sig_i};

   always_comb begin
      state_d  = state_q;
      period_d = period_q;
      step_d   = step_q;
      navg_d   = navg_q;
      delay_d  = delay_q;
      hits_d   = hits_q;
      nsamp_d  = nsamp_q;
      err_d    = err_q;
      if (abort_i) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  if (!period_vld_i || stb_period_i < T_CNT_WIDTH'(2)) begin
                     err_d = 1'b1;
                  end else begin
                     err_d    = 1'b0;
                     period_d = stb_period_i;
                     step_d   = (step_i == '0) ? T_CNT_WIDTH'(1) : step_i;
                     navg_d   = (n_avg_i == '0) ? AVG_WIDTH'(1) : n_avg_i;
                     delay_d  = '0;
                     hits_d   = '0;
                     nsamp_d  = '0;
                     state_d  = ST_ARM;
                  end
               end
            end
            ST_ARM, ST_WAIT_DLY: begin
               if (wd_to) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else if (take_sample) begin
                  hits_d  = hits_inc;
                  nsamp_d = nsamp_q + AVG_WIDTH'(1);
                  state_d = ST_SAMPLE;
               end else if (state_q == ST_ARM && stb_i) begin
                  state_d = ST_WAIT_DLY;
               end
            end
            ST_SAMPLE: begin
               state_d = (nsamp_q >= navg_q) ? ST_EMIT : ST_ARM;
            end
            ST_EMIT: begin
               if (pt_rdy_i) begin
                  delay_d = delay_sum[T_CNT_WIDTH-1:0];
                  hits_d  = '0;
                  nsamp_d = '0;
                  state_d = (delay_sum < {1'b0, period_q}) ? ST_ARM : ST_DONE;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q  <= ST_IDLE;
         period_q <= '0;
         step_q   <= '0;
         navg_q   <= '0;
         delay_q  <= '0;
         hits_q   <= '0;
         nsamp_q  <= '0;
         err_q    <= 1'b0;
         pt_vld_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         period_q <= period_d;
         step_q   <= step_d;
         navg_q   <= navg_d;
         delay_q  <= delay_d;
         hits_q   <= hits_d;
         nsamp_q  <= nsamp_d;
         err_q    <= err_d;
         pt_vld_q <= (state_d == ST_EMIT);
         busy_q   <= (state_d != ST_IDLE);
         // DONE always hands over to IDLE, so done_o lands as busy_o drops.
         done_q   <= (state_q == ST_DONE) && !abort_i;
      end
   end

   assign pt_vld_o    = pt_vld_q;
   assign pt_delay_o  = delay_q;
   assign pt_hits_o   = hits_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_eqt_sampler.sv
// Randomized scoreboard bench for eqt_sampler; sig_i is a window on the
// clocks elapsed since the last strobe, so each delay point has a known level.
`timescale 1ns/1ps
module tb_eqt_sampler;
   import eqt_pkg::*;

   localparam int TW = 32;
   localparam int AW = 16;

   logic          clk_i = 1'b0;
   logic          arst_ni, start_i, abort_i, stb_i, period_vld_i, sig_i, pt_rdy_i;
   logic [TW-1:0] stb_period_i, step_i, pt_delay_o;
   logic [AW-1:0] n_avg_i, pt_hits_o;
   logic          pt_vld_o, busy_o, done_o, err_o;
   eqt_state_e    dbg_state_o;

   eqt_sampler #(.T_CNT_WIDTH(TW), .AVG_WIDTH(AW)) dut (
      .clk_i        (clk_i),
      .arst_ni      (arst_ni),
      .start_i      (start_i),
      .abort_i      (abort_i),
      .stb_i        (stb_i),
      .period_vld_i (period_vld_i),
      .stb_period_i (stb_period_i),
      .sig_i        (sig_i),
      .step_i       (step_i),
      .n_avg_i      (n_avg_i),
      .pt_vld_o     (pt_vld_o),
      .pt_rdy_i     (pt_rdy_i),
      .pt_delay_o   (pt_delay_o),
      .pt_hits_o    (pt_hits_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .err_o        (err_o),
      .dbg_state_o  (dbg_state_o)
   );

   // ---------------- clock ----------------
   always #5 clk_i = ~clk_i;

   // ---------------- scoreboard state ----------------
   logic [TW+AW-1:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- strobe / signal source ----------------
   int gen_period = 100;
   bit stb_en     = 1'b0;
   bit inj_req    = 1'b0;
   int phase      = 0;
   int win_lo     = 0;
   int win_hi     = 0;

   initial begin
      stb_i = 1'b0;
      sig_i = 1'b0;
      forever begin
         @(posedge clk_i); #1;
         if (stb_en && (phase + 1 >= gen_period || inj_req)) begin
            stb_i   = 1'b1;
            phase   = 0;
            inj_req = 1'b0;
         end else begin
            stb_i = 1'b0;
            phase = phase + 1;
         end
         sig_i = (phase >= win_lo && phase < win_hi);
      end
   end

   // ---------------- ready driver ----------------
   int acc_cnt   = 0;
   int hold_idx  = -1;
   int hold_left = 0;
   bit rand_rdy  = 1'b0;

   initial begin
      pt_rdy_i = 1'b0;
      forever begin
         @(posedge clk_i); #1;
         if (pt_vld_o && acc_cnt == hold_idx && hold_left > 0) begin
            pt_rdy_i  = 1'b0;
            hold_left = hold_left - 1;
         end else if (rand_rdy) begin
            pt_rdy_i = ($urandom_range(0, 3) != 0);
         end else begin
            pt_rdy_i = 1'b1;
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin : monitor
      logic [TW+AW-1:0] e;
      bit               stall_q = 1'b0;
      logic [TW-1:0]    stall_dly = '0;
      logic [AW-1:0]    stall_hits = '0;
      forever begin
         @(negedge clk_i);
         if (stall_q) begin
            check("stall_vld", pt_vld_o, 1);
            check("stall_delay", pt_delay_o, stall_dly);
            check("stall_hits", pt_hits_o, stall_hits);
         end
         stall_q    = pt_vld_o && !pt_rdy_i;
         stall_dly  = pt_delay_o;
         stall_hits = pt_hits_o;
         if (pt_vld_o && pt_rdy_i) begin
            acc_cnt++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_point: delay %0d hits %0d, expected no point",
                        pt_delay_o, pt_hits_o);
            end else begin
               e = exp_q.pop_front();
               check("pt_delay", pt_delay_o, e[TW+AW-1:AW]);
               check("pt_hits", pt_hits_o, e[AW-1:0]);
            end
         end
      end
   end

   // ---------------- reference model ----------------
   task automatic push_sweep(input int period, input int step, input int navg);
      int st = (step == 0) ? 1 : step;
      int na = (navg == 0) ? 1 : navg;
      int h;
      for (int d = 0; d < period; d += st) begin
         h = (d >= win_lo && d < win_hi) ? na : 0;
         if (h > 65535) h = 65535;
         exp_q.push_back({TW'(d), AW'(h)});
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic pulse_start();
      @(posedge clk_i); #1;
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
   endtask

   task automatic pulse_abort();
      @(posedge clk_i); #1;
      abort_i = 1'b1;
      @(posedge clk_i); #1;
      abort_i = 1'b0;
   endtask

   task automatic set_params(input int period, input int step, input int navg,
                             input int lo, input int hi);
      gen_period   = period;
      win_lo       = lo;
      win_hi       = hi;
      stb_en       = 1'b1;
      period_vld_i = 1'b1;
      stb_period_i = TW'(period);
      step_i       = TW'(step);
      n_avg_i      = AW'(navg);
   endtask

   task automatic run_sweep(input string name, input int period, input int step,
                            input int navg, input int lo, input int hi);
      bit seen = 1'b0;
      set_params(period, step, navg, lo, hi);
      acc_cnt = 0;
      push_sweep(period, step, navg);
      pulse_start();
      for (int c = 0; c < 30000 && !seen; c++) begin
         @(negedge clk_i);
         if (done_o) seen = 1'b1;
      end
      check({name, "_done_seen"}, seen, 1);
      check({name, "_busy_at_done"}, busy_o, 0);
      check({name, "_points_left"}, exp_q.size(), 0);
      check({name, "_err"}, err_o, 0);
      @(negedge clk_i);
      check({name, "_done_one_cycle"}, done_o, 0);
      if (!seen) pulse_abort();
      exp_q.delete();
   endtask

   task automatic inject_early();
      bit got = 1'b0;
      for (int c = 0; c < 5000 && acc_cnt < 3; c++) @(negedge clk_i);
      for (int c = 0; c < 500 && !got; c++) begin
         @(negedge clk_i);
         if (stb_i) got = 1'b1;
      end
      check("early_ref_strobe", got, 1);
      repeat (39) @(negedge clk_i);
      check("early_in_wait", dbg_state_o, ST_WAIT_DLY);
      inj_req = 1'b1;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      arst_ni      = 1'b0;
      start_i      = 1'b0;
      abort_i      = 1'b0;
      period_vld_i = 1'b0;
      stb_period_i = '0;
      step_i       = '0;
      n_avg_i      = '0;
      repeat (3) @(posedge clk_i);
      #1 arst_ni = 1'b1;
      @(negedge clk_i);
      check("rst_vld", pt_vld_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_err", err_o, 0);
      check("rst_delay", pt_delay_o, 0);
      check("rst_hits", pt_hits_o, 0);
      check("rst_state", dbg_state_o, ST_IDLE);

      // invalid starts
      stb_period_i = TW'(100);
      pulse_start();
      @(negedge clk_i);
      check("inv_novld_err", err_o, 1);
      check("inv_novld_busy", busy_o, 0);
      period_vld_i = 1'b1;
      stb_period_i = TW'(1);
      pulse_start();
      @(negedge clk_i);
      check("inv_short_err", err_o, 1);
      check("inv_short_busy", busy_o, 0);

      // abort together with start in IDLE
      set_params(100, 25, 4, 0, 40);
      @(posedge clk_i); #1;
      start_i = 1'b1;
      abort_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      abort_i = 1'b0;
      @(negedge clk_i);
      check("abort_start_busy", busy_o, 0);
      check("abort_start_state", dbg_state_o, ST_IDLE);

      run_sweep("basic", 100, 25, 4, 0, 40);
      run_sweep("zero_in", 3, 0, 0, 1, 2);

      hold_idx  = 1;
      hold_left = 50;
      run_sweep("backpressure", 100, 25, 4, 10, 60);
      check("bp_hold_used", hold_left, 0);
      hold_idx = -1;

      fork
         run_sweep("early_stb", 100, 25, 1, 75, 76);
         inject_early();
      join

      // abort while waiting for the delay
      begin
         bit got = 1'b0;
         set_params(100, 30, 1, 0, 5);
         acc_cnt = 0;
         exp_q.push_back({TW'(0), AW'(1)});
         pulse_start();
         for (int c = 0; c < 2000 && !got; c++) begin
            @(negedge clk_i);
            if (dbg_state_o == ST_WAIT_DLY) got = 1'b1;
         end
         check("abort_reached_wait", got, 1);
         pulse_abort();
         @(negedge clk_i);
         check("abort_state", dbg_state_o, ST_IDLE);
         check("abort_busy", busy_o, 0);
         check("abort_vld", pt_vld_o, 0);
         repeat (300) @(negedge clk_i);
         check("abort_points_left", exp_q.size(), 0);
         check("abort_accepted", acc_cnt, 1);
         exp_q.delete();
      end

      rand_rdy = 1'b1;
      for (int i = 0; i < 6; i++) begin
         int p  = $urandom_range(4, 30);
         int st = $urandom_range(0, 8);
         int na = $urandom_range(0, 3);
         int lo = $urandom_range(0, p - 1);
         int hi = $urandom_range(lo, p);
         run_sweep($sformatf("rand%0d", i), p, st, na, lo, hi);
      end
      rand_rdy = 1'b0;

`ifdef EQT_TIMEOUT_EN
      begin
         int  n = 0;
         bit  got = 1'b0;
         bit  done_seen = 1'b0;
         set_params(100, 25, 4, 0, 40);
         stb_en = 1'b0;
         repeat (2) @(posedge clk_i);
         pulse_start();
         for (int c = 1; c < 400 && !got; c++) begin
            @(negedge clk_i);
            if (done_o) done_seen = 1'b1;
            if (err_o) begin
               got = 1'b1;
               n   = c;
            end
         end
         check("wd_err", got, 1);
         check("wd_not_early", (n >= 195), 1);
         check("wd_not_late", (n <= 210), 1);
         check("wd_busy", busy_o, 0);
         check("wd_no_done", done_seen, 0);
         stb_en = 1'b1;
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/eqt_sampler.md
# eqt_sampler

Equivalent-time sampler that sits directly downstream of `stb_gen` in the measure unit. It consumes the periodic strobe `stb_i` and measured period `stb_period_i`, then samples the synchronized comparator output at a programmable delay after each strobe. The delay is swept from 0 to the end of the period in `step_i` clock increments, and the block accumulates `n_avg_i` samples per delay point. One hit count per point is streamed out over a valid/ready handshake, which yields a sampled waveform of the repetitive input signal.

## Interface
- `T_CNT_WIDTH`, 32, width of the period and delay counters; must match `stb_gen`.
- `AVG_WIDTH`, 16, width of `n_avg_i` and of the hit counter.
- `clk_i`  in  1  system clock.
- `arst_ni`  in  1  reset, asynchronous and active-low.
- `start_i`  in  1  one-cycle pulse; starts a sweep from IDLE and is ignored otherwise.
- `abort_i`  in  1  returns to IDLE next cycle from any state; no point is emitted.
- `stb_i`  in  1  strobe from `stb_gen`, one clock wide.
- `period_vld_i`  in  1  `stb_gen` ready flag; `stb_period_i` is valid while high.
- `stb_period_i`  in  T_CNT_WIDTH  strobe period in clocks.
- `sig_i`  in  1  comparator output, already synchronized to `clk_i`.
- `step_i`  in  T_CNT_WIDTH  delay increment per point; 0 is treated as 1.
- `n_avg_i`  in  AVG_WIDTH  samples per point; 0 is treated as 1.
- `pt_vld_o`  out  1  point valid.
- `pt_rdy_i`  in  1  point ready from the consumer.
- `pt_delay_o`  out  T_CNT_WIDTH  delay of the point, in clocks after the strobe.
- `pt_hits_o`  out  AVG_WIDTH  number of samples with `sig_i`=1.
- `busy_o`  out  1  high in every state except IDLE.
- `done_o`  out  1  one-cycle pulse when a sweep completes.
- `err_o`  out  1  sticky error flag; cleared by `start_i` or by reset.

## Operation
- States are IDLE, ARM, WAIT_DLY, SAMPLE, EMIT and DONE.
- **IDLE**, on `start_i`:
  - if `period_vld_i`=0 or `stb_period_i`<2: set `err_o` and stay in IDLE;
  - otherwise latch `stb_period_i`, the effective step and the effective `n_avg_i`; set delay:=0, hits:=0, nsamp:=0; go to ARM.
- **ARM**, on `stb_i`:
  - if delay=0: go to SAMPLE in the same cycle as the strobe;
  - otherwise load dcnt:=1 and go to WAIT_DLY.
- **WAIT_DLY**: dcnt increments each cycle. When dcnt=delay, go to SAMPLE.
- **WAIT_DLY, early strobe**: if `stb_i` arrives first, no sample is taken and counting restarts with dcnt:=1, the new strobe being the reference.
- **SAMPLE**:
  - takes one cycle and samples `sig_i` on the cycle the state is entered (delay 0 means the strobe cycle itself);
  - updates hits+=`sig_i` and nsamp+=1;
  - if nsamp reaches the effective `n_avg_i`, go to EMIT; otherwise go to ARM.
- **Hit counter**: it saturates at all-ones.
- **EMIT**:
  - `pt_vld_o`=1; `pt_delay_o` and `pt_hits_o` stay stable until `pt_vld_o`&`pt_rdy_i`;
  - strobes arriving during EMIT are ignored;
  - on the handshake: delay+=step, hits:=0, nsamp:=0; go to ARM if the new delay < latched period, otherwise go to DONE.
- **Delay overflow**: the delay sum is computed one bit wider than T_CNT_WIDTH, so an overflow counts as ≥ period.
- **DONE**: pulses `done_o` for one cycle, then goes to IDLE.
- **Precedence**:
  - `abort_i` has priority over all other events;
  - `start_i` outside IDLE is ignored;
  - if `abort_i` and `start_i` arrive together in IDLE, the block stays in IDLE.
- **Parameter changes**: changing `stb_period_i` in mid-sweep has no effect, because the period is latched.

## Timing
- Every output resets to 0 and the state resets to IDLE.
- From `start_i` to ARM: 1 cycle.
- From strobe to sample: exactly `delay` cycles.
- From the final SAMPLE to `pt_vld_o`: 1 cycle.
- From the handshake to ARM: 1 cycle.
- Because the next cycle is spent in ARM, the block misses at most the strobe that coincides with the handshake cycle.
- `busy_o` falls in the same cycle that `done_o` is high.

## Configuration
- Macro `EQT_TIMEOUT_EN`.
- **When defined**: a watchdog counter runs in ARM and WAIT_DLY and clears on every `stb_i`. If it reaches 2×latched period with no strobe, the block sets `err_o` and goes to IDLE without pulsing `done_o`.
- **When undefined**: there is no watchdog, and ARM waits indefinitely.

## Structure
- Package `eqt_pkg` holds:
  - the `eqt_state_e` enum;
  - the default width constants `EQT_T_CNT_W`=32 and `EQT_AVG_W`=16.
- Sub-module `eqt_dly_cnt` contains the strobe-referenced delay counter (load, increment, compare-equal). It is instantiated once, and the watchdog reuses the same structure.

## Test plan
- **Basic sweep**: period=100, step=25, n_avg=4, `sig_i` high for clocks 0–39 after the strobe → 4 points with delays 0/25/50/75 and hits 4/4/0/0, followed by a `done_o` pulse.
- **Zero-value inputs**: step=0, n_avg=0, period=3 → 3 points (delays 0, 1, 2), each with hits≤1.
- **Backpressure**: hold `pt_rdy_i`=0 for 50 cycles on point 2 → the point's data is stable throughout, no point is lost or duplicated, and the sweep still finishes with 4 points.
- **Early strobe**: period=100, delay=75, inject an extra `stb_i` at dcnt=40 → no sample is taken, and the next sample lands 75 clocks after the injected strobe.
- **Invalid start**: `start_i` with `period_vld_i`=0 → `err_o`=1 and `busy_o` stays 0.
- **Abort and timeout**: `abort_i` in WAIT_DLY → IDLE next cycle with no `pt_vld_o`. With `EQT_TIMEOUT_EN` defined, stopping strobes in a period-100 sweep sets `err_o` after 200 cycles.
